// File: rtl/nrisc_ddata_responder.sv
// -----------------------------------------------------------------------------
// nrisc_ddata_responder
//
// Memory side of the D-Data bus. Serves core loads and stores from an on-chip,
// byte-addressed RAM. Load data is registered and appears one clock after the
// request. After reset an INIT sweep zeroes the RAM one word per clock. Illegal
// accesses are suppressed and recorded in a sticky error flag and address.
//
// Parameters
//   TAM      data word width in bits (multiple of 8, TAM/8 a power of two)
//   N_DData  byte-address width; RAM holds 2^N_DData / (TAM/8) words
//
// Ports
//   clk              clock, all state changes on posedge
//   rst              asynchronous active-low reset
//   DDATA_CORE_addr  byte address
//   DDATA_CORE_in    store data (byte stores use bits [7:0])
//   DDATA_CORE_load  load request
//   DDATA_CORE_write store request
//   DDATA_CORE_ctrl  [1:0] size (00 byte, 01 word, 1x illegal), [2] sign-extend byte loads
//   DDATA_CORE_out   registered load data
//   DDATA_ready      1 once the INIT sweep is done
//   DDATA_err        sticky access-error flag
//   DDATA_err_addr   address of the first faulting access since the last clear
//   DDATA_err_clr    synchronous clear of DDATA_err / DDATA_err_addr
// -----------------------------------------------------------------------------
module nrisc_ddata_responder #(
    parameter int unsigned TAM     = 16,
    parameter int unsigned N_DData = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_DData-1:0] DDATA_CORE_addr,
    input  logic [TAM-1:0]     DDATA_CORE_in,
    input  logic               DDATA_CORE_load,
    input  logic               DDATA_CORE_write,
    input  logic [2:0]         DDATA_CORE_ctrl,
    output logic [TAM-1:0]     DDATA_CORE_out,
    output logic               DDATA_ready,
    output logic               DDATA_err,
    output logic [N_DData-1:0] DDATA_err_addr,
    input  logic               DDATA_err_clr
);

    localparam int unsigned LANES   = TAM / 8;
    localparam int unsigned AddrLsb = $clog2(LANES);
    // Keep the lane select at least one bit wide so single-lane builds still elaborate.
    localparam int unsigned LaneW   = (AddrLsb > 0) ? AddrLsb : 1;
    localparam int unsigned IdxW    = N_DData - AddrLsb;
    localparam int unsigned WORDS   = 1 << IdxW;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(WORDS - 1);

    typedef enum logic {StInit, StIdle} state_e;

    state_e             state_q, state_d;
    logic [IdxW-1:0]    ptr_q, ptr_d;
    logic [TAM-1:0]     out_q, out_d;
    logic               err_q, err_d;
    logic [N_DData-1:0] err_addr_q, err_addr_d;

    logic [TAM-1:0]     mem [WORDS];

    logic [LaneW-1:0]   lane;
    logic [IdxW-1:0]    widx;
    logic               req;
    logic               size_word;
    logic               acc_err;
    logic               ld_ok;
    logic               st_ok;
    logic [TAM-1:0]     rd_word;
    logic [7:0]         rd_byte;

    generate
        if (AddrLsb > 0) begin : g_lane
            assign lane = DDATA_CORE_addr[LaneW-1:0];
        end else begin : g_no_lane
            assign lane = '0;
        end
    endgenerate

    assign widx = DDATA_CORE_addr[N_DData-1:AddrLsb];

    always_comb begin
        req       = DDATA_CORE_load | DDATA_CORE_write;
        size_word = (DDATA_CORE_ctrl[1:0] == 2'b01);
        // Any request that cannot be served: during INIT, conflicting, bad size, or unaligned word.
        acc_err   = req & ((state_q == StInit) |
                           (DDATA_CORE_load & DDATA_CORE_write) |
                           DDATA_CORE_ctrl[1] |
                           (size_word & (lane != '0)));
        ld_ok     = (state_q == StIdle) & DDATA_CORE_load & ~acc_err;
        st_ok     = (state_q == StIdle) & DDATA_CORE_write & ~acc_err;
        rd_word   = mem[widx];
        rd_byte   = rd_word[{lane, 3'b000} +: 8];
    end

    // Next-state: INIT pointer sweep, then IDLE forever.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            StInit: begin
                ptr_d = ptr_q + 1'b1;
                if (ptr_q == LastIdx) begin
                    state_d = StIdle;
                end
            end
            StIdle: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StInit;
            end
        endcase
    end

    // Load data and error capture.
    always_comb begin
        out_d      = out_q;
        err_d      = err_q;
        err_addr_d = err_addr_q;
        if (ld_ok) begin
            if (size_word) begin
                out_d = rd_word;
            end else begin
                out_d = {{(TAM-8){DDATA_CORE_ctrl[2] & rd_byte[7]}}, rd_byte};
            end
        end
        // Clear takes priority, so an error in the same cycle is dropped.
        if (DDATA_err_clr) begin
            err_d      = 1'b0;
            err_addr_d = '0;
        end else if (acc_err && !err_q) begin
            err_d      = 1'b1;
            err_addr_d = DDATA_CORE_addr;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StInit;
            ptr_q      <= '0;
            out_q      <= '0;
            err_q      <= 1'b0;
            err_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            out_q      <= out_d;
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
        end
    end

    // RAM has no reset; INIT owns the write port until the sweep completes.
    always_ff @(posedge clk) begin
        if (state_q == StInit) begin
            mem[ptr_q] <= '0;
        end else if (st_ok) begin
            if (size_word) begin
                mem[widx] <= DDATA_CORE_in;
            end else begin
                mem[widx][{lane, 3'b000} +: 8] <= DDATA_CORE_in[7:0];
            end
        end
    end

    assign DDATA_CORE_out = out_q;
    assign DDATA_ready    = (state_q == StIdle);
    assign DDATA_err      = err_q;
    assign DDATA_err_addr = err_addr_q;

endmodule

// File: tb/tb_nrisc_ddata_responder.sv
module tb_nrisc_ddata_responder;

    localparam int TAM = 16;
    localparam int NA  = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NA-1:0] addr = '0;
    logic [15:0]   din = '0;
    logic          load = 1'b0;
    logic          write = 1'b0;
    logic [2:0]    ctrl = '0;
    logic [15:0]   dout;
    logic          ready;
    logic          err;
    logic [NA-1:0] err_addr;
    logic          err_clr = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    logic chk_en = 1'b0;

    always #5 clk = ~clk;

    nrisc_ddata_responder #(
        .TAM     (TAM),
        .N_DData (NA)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .DDATA_CORE_addr  (addr),
        .DDATA_CORE_in    (din),
        .DDATA_CORE_load  (load),
        .DDATA_CORE_write (write),
        .DDATA_CORE_ctrl  (ctrl),
        .DDATA_CORE_out   (dout),
        .DDATA_ready      (ready),
        .DDATA_err        (err),
        .DDATA_err_addr   (err_addr),
        .DDATA_err_clr    (err_clr)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: flat byte array, little-endian lanes, cycle count since reset.
    logic [7:0]  m_mem [256];
    int          m_cnt   = 0;
    logic [15:0] m_out   = '0;
    logic        m_err   = 1'b0;
    logic [7:0]  m_eaddr = '0;

    function automatic logic bad_req(input int cnt, input logic ld, input logic wr,
                                     input logic [2:0] c, input logic [7:0] a);
        if (!(ld || wr)) return 1'b0;
        return (cnt < 128) || (ld && wr) || c[1] || (c[0] && a[0]);
    endfunction

    function automatic logic [15:0] model_load(input logic [7:0] lo, input logic [7:0] hi,
                                               input logic [2:0] c);
        if (c[0]) return {hi, lo};
        return {((c[2] && lo[7]) ? 8'hFF : 8'h00), lo};
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_cnt   <= 0;
            m_out   <= '0;
            m_err   <= 1'b0;
            m_eaddr <= '0;
        end else begin
            if (err_clr) begin
                m_err   <= 1'b0;
                m_eaddr <= '0;
            end else if (bad_req(m_cnt, load, write, ctrl, addr) && !m_err) begin
                m_err   <= 1'b1;
                m_eaddr <= addr;
            end
            if (!bad_req(m_cnt, load, write, ctrl, addr)) begin
                if (write) begin
                    m_mem[addr] <= din[7:0];
                    if (ctrl[0]) m_mem[addr | 8'h01] <= din[15:8];
                end
                if (load) m_out <= model_load(m_mem[addr], m_mem[addr | 8'h01], ctrl);
            end
            if (m_cnt < 128) m_cnt <= m_cnt + 1;
            // Sweep outcome: every byte is zero once the last INIT word is written.
            if (m_cnt == 127) begin
                for (int i = 0; i < 256; i++) m_mem[i] <= 8'h00;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("out", {16'h0, dout}, {16'h0, m_out});
            check("ready", {31'h0, ready}, {31'h0, (m_cnt >= 128)});
            check("err", {31'h0, err}, {31'h0, m_err});
            check("err_addr", {24'h0, err_addr}, {24'h0, m_eaddr});
        end
    end

    // One call = one sampled posedge with these inputs.
    task automatic cyc(input logic l, input logic w, input logic [2:0] c, input int a,
                       input logic [15:0] d, input logic clr);
        @(negedge clk);
        #1;
        load    = l;
        write   = w;
        ctrl    = c;
        addr    = 8'(a);
        din     = d;
        err_clr = clr;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 3'b000, 0, 16'h0, 1'b0);
    endtask

    task automatic ld_chk(input string name, input logic [2:0] c, input int a,
                          input logic [15:0] exp);
        cyc(1'b1, 1'b0, c, a, 16'h0, 1'b0);
        idle();
        check(name, {16'h0, dout}, {16'h0, exp});
    endtask

    task automatic wait_ready(input string name, input logic init_req);
        int n;
        n = 0;
        while (!ready && n < 400) begin
            @(posedge clk);
            #1;
            n++;
            if (init_req && n == 100) begin
                write = 1'b1;
                ctrl  = 3'b001;
                addr  = 8'h00;
                din   = 16'hBEEF;
            end
            if (init_req && n == 101) begin
                write = 1'b0;
                ctrl  = 3'b000;
                din   = 16'h0;
                check("init_req_err", {31'h0, err}, 32'h1);
            end
        end
        check(name, n, 128);
    endtask

    initial begin
        #3 rst = 1'b0;
        #20;
        chk_en = 1'b1;
        @(negedge clk);
        #1 rst = 1'b1;

        // 1: INIT sweep length, then all words read zero
        wait_ready("ready_latency", 1'b0);
        for (int a = 0; a < 256; a += 2) cyc(1'b1, 1'b0, 3'b001, a, 16'h0, 1'b0);
        idle();
        check("t1_out_zero", {16'h0, dout}, 32'h0);

        // 2: sized stores and loads, byte store ignores upper input bits
        cyc(1'b0, 1'b1, 3'b001, 8'h10, 16'hA55A, 1'b0);
        cyc(1'b0, 1'b1, 3'b000, 8'h11, 16'h3C80, 1'b0);
        ld_chk("t2_sext", 3'b100, 8'h11, 16'hFF80);
        ld_chk("t2_zext", 3'b000, 8'h11, 16'h0080);
        ld_chk("t2_word", 3'b001, 8'h10, 16'h805A);
        ld_chk("t2_sext_pos", 3'b100, 8'h10, 16'h005A);

        // 3: read-after-write and hold
        cyc(1'b0, 1'b1, 3'b001, 8'h20, 16'h1234, 1'b0);
        cyc(1'b1, 1'b0, 3'b001, 8'h20, 16'h0, 1'b0);
        idle();
        check("t3_raw", {16'h0, dout}, 32'h1234);
        idle();
        idle();
        idle();
        check("t3_hold", {16'h0, dout}, 32'h1234);

        // 4: misaligned word, sticky address, clear, clear-wins
        cyc(1'b1, 1'b0, 3'b001, 8'h21, 16'h0, 1'b0);
        idle();
        check("t4_err", {31'h0, err}, 32'h1);
        check("t4_eaddr", {24'h0, err_addr}, 32'h21);
        check("t4_out_held", {16'h0, dout}, 32'h1234);
        cyc(1'b1, 1'b1, 3'b001, 8'h30, 16'hFFFF, 1'b0);
        idle();
        check("t4_eaddr_sticky", {24'h0, err_addr}, 32'h21);
        cyc(1'b0, 1'b0, 3'b000, 0, 16'h0, 1'b1);
        idle();
        check("t4_clr_err", {31'h0, err}, 32'h0);
        check("t4_clr_eaddr", {24'h0, err_addr}, 32'h0);
        cyc(1'b1, 1'b0, 3'b011, 8'h33, 16'h0, 1'b1);
        idle();
        check("t4_clr_wins", {31'h0, err}, 32'h0);
        ld_chk("t4_lw_no_store", 3'b001, 8'h30, 16'h0000);

        // 5: illegal size store suppressed
        cyc(1'b0, 1'b1, 3'b010, 8'h40, 16'hFFFF, 1'b0);
        idle();
        check("t5_err", {31'h0, err}, 32'h1);
        check("t5_eaddr", {24'h0, err_addr}, 32'h40);
        cyc(1'b0, 1'b0, 3'b000, 0, 16'h0, 1'b1);
        ld_chk("t5_ram_untouched", 3'b001, 8'h40, 16'h0000);

        // 6: reset mid-INIT restarts sweep; request in INIT is an error and writes nothing
        cyc(1'b0, 1'b1, 3'b001, 8'h50, 16'h5555, 1'b0);
        ld_chk("t6_pre", 3'b001, 8'h50, 16'h5555);
        @(negedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        #1 rst = 1'b1;
        repeat (60) @(posedge clk);
        #1 rst = 1'b0;
        check("t6_rst_ready", {31'h0, ready}, 32'h0);
        #7 rst = 1'b1;
        wait_ready("t6_ready_latency", 1'b1);
        ld_chk("t6_init_req_nowrite", 3'b001, 8'h00, 16'h0000);
        ld_chk("t6_cleared", 3'b001, 8'h50, 16'h0000);
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
